buyruk_getir: RTL and testbench

Instruction fetch stage sitting directly upstream of the `islemci` core. Generates word addresses to the synchronous instruction memory (`buyruk_bellek`), buffers returned words with their `ps` in a small prefetch queue, and hands them to the core over a valid/ready handshake. Taken branches and jumps from the core redirect fetch, flushing the queue and discarding any in-flight memory response.

---
 rtl/buyruk_getir_pkg.sv | 13 +
 rtl/buyruk_getir_if.sv | 43 ++++
 rtl/buyruk_getir_kuyrugu.sv | 76 +++++++
 rtl/buyruk_getir.sv | 130 +++++++++++++
 tb/tb_buyruk_getir.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/buyruk_getir_pkg.sv
// Shared constants and the prefetch queue entry type for the buyruk_getir fetch stage.
package getir_pkg;

  localparam logic [31:0] NOP_BUYRUK              = 32'h0000_0013;
  localparam logic [31:0] VARSAYILAN_BASLANGIC_PS = 32'h0000_0000;
  localparam int          VARSAYILAN_DERINLIK     = 4;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] buyruk;
  } kuyruk_girdi_t;

endpackage

// File: rtl/buyruk_getir_if.sv
// Memory and core-side signals of the fetch stage; fault outputs exist only with FETCH_ALIGN_CHECK_EN.
interface buyruk_getir_if #(
  parameter int BELLEK_ADR_W = 7
);

  logic                    bellek_oku;
  logic [BELLEK_ADR_W-1:0] bellek_adres;
  logic [31:0]             bellek_veri;
  logic                    yonlendir;
  logic [31:0]             yonlendir_ps;
  logic [31:0]             buyruk;
  logic [31:0]             buyruk_ps;
  logic                    buyruk_gecerli;
  logic                    buyruk_hazir;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                    hizalama_hata;
  logic [31:0]             hata_ps;

  modport master (
    output bellek_oku, bellek_adres, buyruk, buyruk_ps, buyruk_gecerli,
           hizalama_hata, hata_ps,
    input  bellek_veri, yonlendir, yonlendir_ps, buyruk_hazir
  );

  modport slave (
    input  bellek_oku, bellek_adres, buyruk, buyruk_ps, buyruk_gecerli,
           hizalama_hata, hata_ps,
    output bellek_veri, yonlendir, yonlendir_ps, buyruk_hazir
  );
`else
  modport master (
    output bellek_oku, bellek_adres, buyruk, buyruk_ps, buyruk_gecerli,
    input  bellek_veri, yonlendir, yonlendir_ps, buyruk_hazir
  );

  modport slave (
    input  bellek_oku, bellek_adres, buyruk, buyruk_ps, buyruk_gecerli,
    output bellek_veri, yonlendir, yonlendir_ps, buyruk_hazir
  );
`endif

endinterface

// File: rtl/buyruk_getir_kuyrugu.sv
// Prefetch FIFO of {ps, buyruk} entries; flush wins over push and pop in the same cycle.
module buyruk_kuyrugu
  import getir_pkg::*;
#(
  parameter  int DERINLIK = VARSAYILAN_DERINLIK,
  localparam int AW       = $clog2(DERINLIK),
  localparam int CW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  kuyruk_girdi_t push_veri_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output kuyruk_girdi_t bas_o,
  output logic          bos_degil_o,
  output logic [CW-1:0] doluluk_o
);

  kuyruk_girdi_t mem_q [DERINLIK];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] doluluk_q, doluluk_d;
  logic          push_s, pop_s;

  // Pointer and occupancy next-state
  always_comb begin
    push_s    = push_i && !flush_i;
    pop_s     = pop_i && !flush_i && (doluluk_q != {CW{1'b0}});
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    doluluk_d = doluluk_q;
    if (flush_i) begin
      wr_ptr_d  = {AW{1'b0}};
      rd_ptr_d  = {AW{1'b0}};
      doluluk_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      doluluk_d = doluluk_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      doluluk_q <= {CW{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      doluluk_q <= doluluk_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so it carries no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_veri_i;
    end
  end

  assign bas_o       = mem_q[rd_ptr_q];
  assign bos_degil_o = (doluluk_q != {CW{1'b0}});
  assign doluluk_o   = doluluk_q;

endmodule

// File: rtl/buyruk_getir.sv
// Instruction fetch stage: credit-based memory issue, prefetch queue, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module buyruk_getir
  import getir_pkg::*;
#(
  parameter int          DERINLIK     = VARSAYILAN_DERINLIK,
  parameter int          BELLEK_ADR_W = 7,
  parameter logic [31:0] BASLANGIC_PS = VARSAYILAN_BASLANGIC_PS
) (
  input logic            clk,
  input logic            rst,
  buyruk_getir_if.master arayuz
);

  localparam int CW = $clog2(DERINLIK) + 1;

  logic [31:0]   getir_ps_q, getir_ps_d;
  logic [31:0]   bekleyen_ps_q, bekleyen_ps_d;
  logic          bekleyen_q, bekleyen_d;
  logic          pop_s, oku_s, durdur_s;
  logic [31:0]   hedef_ps_s;
  logic [CW:0]   kredi_s;
  logic [CW-1:0] doluluk_s;
  logic          bos_degil_s;
  kuyruk_girdi_t bas_s, push_veri_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        hata_q, hata_d;
  logic [31:0] hata_ps_q, hata_ps_d;

  // Sticky fault capture on the first misaligned redirect
  always_comb begin
    hata_d    = hata_q;
    hata_ps_d = hata_ps_q;
    if (arayuz.yonlendir && (arayuz.yonlendir_ps[1:0] != 2'b00) && !hata_q) begin
      hata_d    = 1'b1;
      hata_ps_d = arayuz.yonlendir_ps;
    end else begin
      hata_d    = hata_q;
      hata_ps_d = hata_ps_q;
    end
  end

  // Fault register
  always_ff @(posedge clk) begin
    if (rst) begin
      hata_q    <= 1'b0;
      hata_ps_q <= 32'h0000_0000;
    end else begin
      hata_q    <= hata_d;
      hata_ps_q <= hata_ps_d;
    end
  end

  assign hedef_ps_s           = arayuz.yonlendir_ps;
  assign durdur_s             = hata_q;
  assign arayuz.hizalama_hata = hata_q;
  assign arayuz.hata_ps       = hata_ps_q;
`else
  assign hedef_ps_s = arayuz.yonlendir_ps & 32'hFFFF_FFFC;
  assign durdur_s   = 1'b0;
`endif

  // Entries already queued plus the one in flight must leave room for a new request
  assign pop_s   = bos_degil_s && arayuz.buyruk_hazir;
  assign kredi_s = {1'b0, doluluk_s} + (CW+1)'(bekleyen_q) - (CW+1)'(pop_s);
  assign oku_s   = !rst && !arayuz.yonlendir && !durdur_s && (kredi_s < (CW+1)'(DERINLIK));

  assign arayuz.bellek_oku   = oku_s;
  assign arayuz.bellek_adres = getir_ps_q[BELLEK_ADR_W+1:2];

  // Fetch address and in-flight tracking next-state
  always_comb begin
    getir_ps_d    = getir_ps_q;
    bekleyen_ps_d = bekleyen_ps_q;
    bekleyen_d    = oku_s;
    if (arayuz.yonlendir) begin
      getir_ps_d = hedef_ps_s;
    end else if (oku_s) begin
      getir_ps_d    = getir_ps_q + 32'd4;
      bekleyen_ps_d = getir_ps_q;
    end else begin
      getir_ps_d    = getir_ps_q;
      bekleyen_ps_d = bekleyen_ps_q;
    end
  end

  // Fetch state register
  always_ff @(posedge clk) begin
    if (rst) begin
      getir_ps_q    <= BASLANGIC_PS;
      bekleyen_ps_q <= 32'h0000_0000;
      bekleyen_q    <= 1'b0;
    end else begin
      getir_ps_q    <= getir_ps_d;
      bekleyen_ps_q <= bekleyen_ps_d;
      bekleyen_q    <= bekleyen_d;
    end
  end

  assign push_veri_s.ps     = bekleyen_ps_q;
  assign push_veri_s.buyruk = arayuz.bellek_veri;

  buyruk_kuyrugu #(
    .DERINLIK (DERINLIK)
  ) u_kuyruk (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bekleyen_q),
    .push_veri_i (push_veri_s),
    .pop_i       (pop_s),
    .flush_i     (arayuz.yonlendir),
    .bas_o       (bas_s),
    .bos_degil_o (bos_degil_s),
    .doluluk_o   (doluluk_s)
  );

  // Head presentation: NOP at address zero while the queue is empty
  always_comb begin
    arayuz.buyruk_gecerli = bos_degil_s;
    if (bos_degil_s) begin
      arayuz.buyruk    = bas_s.buyruk;
      arayuz.buyruk_ps = bas_s.ps;
    end else begin
      arayuz.buyruk    = NOP_BUYRUK;
      arayuz.buyruk_ps = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_buyruk_getir.sv
// Directed bench for buyruk_getir with a one-cycle-latency instruction memory model.
module tb_buyruk_getir;
  import getir_pkg::*;

  logic clk;
  logic rst;
  int   kontrol_sayisi;
  int   hata_sayisi;

  logic [31:0] bellek [128];
  logic [31:0] oku_veri;

  buyruk_getir_if #(.BELLEK_ADR_W(7)) arayuz ();

  buyruk_getir #(
    .DERINLIK     (4),
    .BELLEK_ADR_W (7),
    .BASLANGIC_PS (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arayuz (arayuz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory: data one cycle after the read request
  always @(posedge clk) begin
    if (arayuz.bellek_oku) begin
      oku_veri <= bellek[arayuz.bellek_adres];
    end
  end
  assign arayuz.bellek_veri = oku_veri;

  // Words 0..7: small ADDI/BLT loop; the rest carry their own index
  function automatic logic [31:0] soz(input int idx);
    case (idx)
      0:       soz = 32'h0010_0093;
      1:       soz = 32'h0050_0113;
      2:       soz = 32'h0010_8093;
      3:       soz = 32'h0020_8193;
      4:       soz = 32'hFE20_CEE3;
      5:       soz = 32'h0000_0013;
      6:       soz = 32'h0030_0213;
      7:       soz = 32'h0042_0293;
      default: soz = 32'hA000_0000 | 32'(idx);
    endcase
  endfunction

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic saat();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL zaman_asimi: gozlenen=asildi beklenen=bitis");
    $fatal(1, "zaman asimi");
  end

  initial begin
    kontrol_sayisi = 0;
    hata_sayisi    = 0;
    for (int i = 0; i < 128; i++) bellek[i] = soz(i);
    rst                 = 1'b1;
    arayuz.buyruk_hazir = 1'b1;
    arayuz.yonlendir    = 1'b0;
    arayuz.yonlendir_ps = 32'h0000_0000;
    saat();
    saat();

    kontrol("rst_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
    kontrol("rst_buyruk", arayuz.buyruk, 32'h0000_0013);
    kontrol("rst_ps", arayuz.buyruk_ps, 32'h0000_0000);
    kontrol("rst_oku", 32'(arayuz.bellek_oku), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    kontrol("rst_hata", 32'(arayuz.hizalama_hata), 32'd0);
    kontrol("rst_hata_ps", arayuz.hata_ps, 32'h0000_0000);
`endif

    // Startup and steady stream
    rst = 1'b0;
    #1;
    kontrol("ilk_oku", 32'(arayuz.bellek_oku), 32'd1);
    kontrol("ilk_adres", 32'(arayuz.bellek_adres), 32'd0);
    saat();
    kontrol("ilk_gecerli_dusuk", 32'(arayuz.buyruk_gecerli), 32'd0);
    saat();
    kontrol("ilk_gecerli", 32'(arayuz.buyruk_gecerli), 32'd1);
    kontrol("akis_ps0", arayuz.buyruk_ps, 32'h0000_0000);
    kontrol("akis_soz0", arayuz.buyruk, 32'h0010_0093);
    for (int k = 1; k < 8; k++) begin
      saat();
      kontrol($sformatf("akis_ps%0d", k), arayuz.buyruk_ps, 32'(4 * k));
      kontrol($sformatf("akis_soz%0d", k), arayuz.buyruk, soz(k));
    end

    // Back-pressure: queue fills, issue stops, stream resumes intact
    arayuz.buyruk_hazir = 1'b0;
    for (int k = 0; k < 10; k++) saat();
    kontrol("dolu_doluluk", 32'(dut.u_kuyruk.doluluk_o), 32'd4);
    kontrol("dolu_oku", 32'(arayuz.bellek_oku), 32'd0);
    kontrol("dolu_ps", arayuz.buyruk_ps, 32'h0000_001C);
    arayuz.buyruk_hazir = 1'b1;
    #1;
    kontrol("birak_oku", 32'(arayuz.bellek_oku), 32'd1);
    for (int k = 8; k < 14; k++) begin
      saat();
      kontrol($sformatf("birak_ps%0d", k), arayuz.buyruk_ps, 32'(4 * k));
      kontrol($sformatf("birak_soz%0d", k), arayuz.buyruk, soz(k));
    end

    // Redirect with a request in flight
    arayuz.yonlendir    = 1'b1;
    arayuz.yonlendir_ps = 32'h0000_0018;
    #1;
    kontrol("yon_oku_yok", 32'(arayuz.bellek_oku), 32'd0);
    saat();
    arayuz.yonlendir = 1'b0;
    #1;
    kontrol("yon1_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
    kontrol("yon1_oku", 32'(arayuz.bellek_oku), 32'd1);
    kontrol("yon1_adres", 32'(arayuz.bellek_adres), 32'd6);
    saat();
    kontrol("yon2_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
    saat();
    kontrol("yon3_gecerli", 32'(arayuz.buyruk_gecerli), 32'd1);
    kontrol("yon3_ps", arayuz.buyruk_ps, 32'h0000_0018);
    kontrol("yon3_soz", arayuz.buyruk, 32'h0030_0213);
    saat();
    kontrol("yon4_ps", arayuz.buyruk_ps, 32'h0000_001C);

    // Redirect plus pop while full
    arayuz.buyruk_hazir = 1'b0;
    for (int k = 0; k < 6; k++) saat();
    kontrol("dolu2_doluluk", 32'(dut.u_kuyruk.doluluk_o), 32'd4);
    arayuz.buyruk_hazir = 1'b1;
    arayuz.yonlendir    = 1'b1;
    arayuz.yonlendir_ps = 32'h0000_0040;
    saat();
    arayuz.yonlendir = 1'b0;
    #1;
    kontrol("bosalt_doluluk", 32'(dut.u_kuyruk.doluluk_o), 32'd0);
    kontrol("bosalt_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
    saat();
    kontrol("bosalt2_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
    saat();
    kontrol("bosalt3_ps", arayuz.buyruk_ps, 32'h0000_0040);
    kontrol("bosalt3_soz", arayuz.buyruk, 32'hA000_0010);
    saat();
    kontrol("bosalt4_ps", arayuz.buyruk_ps, 32'h0000_0044);

    // Memory address wrap at 128 words
    arayuz.yonlendir    = 1'b1;
    arayuz.yonlendir_ps = 32'h0000_01F8;
    saat();
    arayuz.yonlendir = 1'b0;
    #1;
    kontrol("sar_adres7e", 32'(arayuz.bellek_adres), 32'h7E);
    saat();
    kontrol("sar_adres7f", 32'(arayuz.bellek_adres), 32'h7F);
    saat();
    kontrol("sar_adres0", 32'(arayuz.bellek_adres), 32'h00);
    kontrol("sar_ps1f8", arayuz.buyruk_ps, 32'h0000_01F8);
    kontrol("sar_soz126", arayuz.buyruk, 32'hA000_007E);
    saat();
    kontrol("sar_ps1fc", arayuz.buyruk_ps, 32'h0000_01FC);
    kontrol("sar_soz127", arayuz.buyruk, 32'hA000_007F);
    saat();
    kontrol("sar_ps200", arayuz.buyruk_ps, 32'h0000_0200);
    kontrol("sar_soz0", arayuz.buyruk, 32'h0010_0093);

    // Misaligned redirect target
    arayuz.yonlendir    = 1'b1;
    arayuz.yonlendir_ps = 32'h0000_0022;
    saat();
    arayuz.yonlendir = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    kontrol("hiza_hata", 32'(arayuz.hizalama_hata), 32'd1);
    kontrol("hiza_hata_ps", arayuz.hata_ps, 32'h0000_0022);
    kontrol("hiza_oku1", 32'(arayuz.bellek_oku), 32'd0);
    for (int k = 0; k < 3; k++) saat();
    kontrol("hiza_oku4", 32'(arayuz.bellek_oku), 32'd0);
    kontrol("hiza_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
`else
    kontrol("hiza_adres", 32'(arayuz.bellek_adres), 32'd8);
    saat();
    saat();
    kontrol("hiza_ps", arayuz.buyruk_ps, 32'h0000_0020);
    kontrol("hiza_soz", arayuz.buyruk, 32'hA000_0008);
`endif

    // Reset again clears everything
    rst = 1'b1;
    saat();
    kontrol("rst2_gecerli", 32'(arayuz.buyruk_gecerli), 32'd0);
    kontrol("rst2_buyruk", arayuz.buyruk, 32'h0000_0013);
    kontrol("rst2_oku", 32'(arayuz.bellek_oku), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    kontrol("rst2_hata", 32'(arayuz.hizalama_hata), 32'd0);
`endif
    rst = 1'b0;
    #1;
    kontrol("rst2_adres", 32'(arayuz.bellek_adres), 32'd0);

    $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
    $finish;
  end

endmodule
